// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with the writeback result mux and a retired-instruction counter.
// All W-stage outputs come from registers, giving exactly one cycle of latency from the M inputs.
module mem_wb_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallW,
   input  logic             FlushW,
   input  logic             ValidM,
   input  logic             RegWriteM,
   input  logic [1:0]       ResultSrcM,
   input  logic [XLEN-1:0]  ALUResultM,
   input  logic [XLEN-1:0]  ReadDataM,
   input  logic [4:0]       RdM,
   input  logic [XLEN-1:0]  PCPlus4M,
   output logic             ValidW,
   output logic             RegWriteW,
   output logic [4:0]       RdW,
   output logic [XLEN-1:0]  ResultW,
   output logic [CNT_W-1:0] RetiredCount
);

   logic             valid_q;
   logic             reg_write_q;
   logic [4:0]       rd_q;
   logic [1:0]       result_src_q;
   logic [XLEN-1:0]  alu_result_q;
   logic [XLEN-1:0]  read_data_q;
   logic [XLEN-1:0]  pc_plus4_q;
   logic [CNT_W-1:0] retired_q;

   logic             advance;
   logic             reg_write_qual;

   // Flush overrides stall, so the W slot is replaced whenever either lets it move.
   assign advance        = ~StallW | FlushW;
   assign reg_write_qual = RegWriteM & ValidM & (RdM != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_q        <= 5'd0;
      end else if (FlushW) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_q        <= 5'd0;
      end else if (!StallW) begin
         valid_q     <= ValidM;
         reg_write_q <= reg_write_qual;
         rd_q        <= RdM;
      end
   end

   // Data registers load on flush too; their contents behind a bubble are never consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_src_q <= 2'b00;
         alu_result_q <= '0;
         read_data_q  <= '0;
         pc_plus4_q   <= '0;
      end else if (advance) begin
         result_src_q <= ResultSrcM;
         alu_result_q <= ALUResultM;
         read_data_q  <= ReadDataM;
         pc_plus4_q   <= PCPlus4M;
      end
   end

   // An instruction retires on the edge it leaves W, so a long stall still counts it once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= '0;
      end else if (valid_q && advance) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      ResultW = '0;
      unique case (result_src_q)
         2'b00: ResultW = alu_result_q;
         2'b01: ResultW = read_data_q;
         2'b10: ResultW = pc_plus4_q;
         2'b11: ResultW = '0;
      endcase
   end

   assign ValidW       = valid_q;
   assign RegWriteW    = reg_write_q;
   assign RdW          = rd_q;
   assign RetiredCount = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             StallW, FlushW, ValidM, RegWriteM;
   logic [1:0]       ResultSrcM;
   logic [XLEN-1:0]  ALUResultM, ReadDataM, PCPlus4M;
   logic [4:0]       RdM;
   logic             ValidW, RegWriteW;
   logic [4:0]       RdW;
   logic [XLEN-1:0]  ResultW;
   logic [CNT_W-1:0] RetiredCount;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: what occupies the W slot, and how many have retired.
   bit          m_valid;
   bit          m_wr;
   int unsigned m_rd;
   int unsigned m_result;
   bit          m_result_known;
   int unsigned m_retired;

   mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .StallW       (StallW),
      .FlushW       (FlushW),
      .ValidM       (ValidM),
      .RegWriteM    (RegWriteM),
      .ResultSrcM   (ResultSrcM),
      .ALUResultM   (ALUResultM),
      .ReadDataM    (ReadDataM),
      .RdM          (RdM),
      .PCPlus4M     (PCPlus4M),
      .ValidW       (ValidW),
      .RegWriteW    (RegWriteW),
      .RdW          (RdW),
      .ResultW      (ResultW),
      .RetiredCount (RetiredCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid        = 1'b0;
      m_wr           = 1'b0;
      m_rd           = 0;
      m_result       = 0;
      m_result_known = 1'b1;
      m_retired      = 0;
   endtask

   // Advances the model by one clock edge using the inputs presented before that edge.
   task automatic model_edge();
      bit leaving;
      leaving = !StallW || FlushW;
      if (m_valid && leaving) m_retired = (m_retired + 1) % (1 << CNT_W);
      if (FlushW) begin
         m_valid        = 1'b0;
         m_wr           = 1'b0;
         m_rd           = 0;
         m_result_known = 1'b0;
      end else if (!StallW) begin
         m_valid = ValidM;
         m_rd    = RdM;
         m_wr    = ValidM && RegWriteM && (RdM != 0);
         case (ResultSrcM)
            2'd0:    m_result = ALUResultM;
            2'd1:    m_result = ReadDataM;
            2'd2:    m_result = PCPlus4M;
            default: m_result = 0;
         endcase
         m_result_known = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"},    {31'd0, ValidW},       {31'd0, m_valid});
      check({tag, ".regwrite"}, {31'd0, RegWriteW},    {31'd0, m_wr});
      check({tag, ".rd"},       {27'd0, RdW},          m_rd);
      check({tag, ".count"},    {28'd0, RetiredCount}, m_retired);
      if (m_result_known) check({tag, ".result"}, ResultW, m_result);
   endtask

   task automatic drive(input bit v, input bit w, input logic [1:0] src, input int unsigned alu,
                        input int unsigned rdata, input int unsigned rd, input int unsigned pc4,
                        input bit stall, input bit flush);
      ValidM     = v;
      RegWriteM  = w;
      ResultSrcM = src;
      ALUResultM = alu;
      ReadDataM  = rdata;
      RdM        = 5'(rd);
      PCPlus4M   = pc4;
      StallW     = stall;
      FlushW     = flush;
   endtask

   task automatic drive_random(input int unsigned stall_pct, input int unsigned flush_pct);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom_range(0, 31), $urandom,
            $urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < flush_pct);
   endtask

   // Inputs change after the falling edge; outputs are compared at the next falling edge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      check_outputs(tag);
   endtask

   // Reset pulse entirely between two rising edges; outputs must clear before the next edge.
   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      drive_random(30, 30);
      #1;
      check_outputs("reset_init");
      for (int i = 0; i < 3; i++) begin
         drive_random(30, 30);
         tick("reset_hold");
      end
      rst = 1'b0;

      drive(1, 1, 2'b00, 32'h0000_1234, 0, 5, 0, 0, 0);
      tick("first_load");
      check("first_result", ResultW, 32'h0000_1234);
      drive(1, 1, 2'b01, 0, 32'hDEAD_BEEF, 6, 0, 0, 0);
      tick("mux_mem");
      check("first_retired", {28'd0, RetiredCount}, 32'd1);
      drive(1, 1, 2'b10, 32'h55, 32'h66, 8, 32'h104, 0, 0);
      tick("mux_pc4");
      drive(1, 1, 2'b11, 32'h55, 32'h66, 9, 32'h104, 0, 0);
      tick("mux_zero");
      drive(1, 1, 2'b00, 32'h77, 0, 0, 0, 0, 0);
      tick("x0_suppress");

      drive(1, 1, 2'b00, 32'hA, 0, 7, 0, 0, 0);
      tick("stall_load_a");
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2'b00, 32'hB, 0, 12, 0, 1, 0);
         tick("stall_hold");
      end
      drive(1, 1, 2'b00, 32'hB, 0, 12, 0, 0, 0);
      tick("stall_release");
      drive(1, 1, 2'b00, 32'hC, 0, 13, 0, 1, 0);
      tick("stall_again");
      drive(1, 1, 2'b01, 0, 32'hD, 14, 0, 1, 1);
      tick("flush_with_stall");
      drive(0, 1, 2'b00, 32'hE, 0, 15, 0, 1, 0);
      tick("stall_bubble");
      drive(1, 1, 2'b00, 32'hF, 0, 16, 0, 0, 0);
      tick("after_bubble");

      drive(1, 1, 2'b00, 32'h1, 0, 3, 0, 1, 1);
      pulse_reset("async_reset");
      tick("post_reset_load");

      pulse_reset("wrap_reset");
      for (int i = 0; i < 17; i++) begin
         drive(1, $urandom_range(0, 1) == 1, 2'b00, i, 0, i + 1, 0, 0, 0);
         tick("wrap_load");
      end
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      tick("wrap_drain");
      check("wrap_count", {28'd0, RetiredCount}, 32'd1);

      for (int i = 0; i < 400; i++) begin
         drive_random(25, 10);
         if ($urandom_range(0, 99) == 0) pulse_reset("rand_reset");
         tick("random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the Memory stage and the register file, plus the writeback result mux.
- Captures the M-stage control and data every cycle, subject to stall and flush.
- Produces ResultW, RdW and RegWriteW for the register file and the hazard/forwarding unit.
- Keeps a retired-instruction counter for debug and performance measurement.

Parameters:
- XLEN, 32, data path width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- StallW  input  1  hold all W-stage registers unchanged.
- FlushW  input  1  insert a bubble into W.
- ValidM  input  1  the M stage holds a real instruction.
- RegWriteM  input  1  register-file write enable from M.
- ResultSrcM  input  2  result select from M: 00 ALU, 01 memory, 10 PC+4.
- ALUResultM  input  XLEN  ALU result or address from M.
- ReadDataM  input  XLEN  data-memory read data, valid in the M cycle.
- RdM  input  5  destination register from M.
- PCPlus4M  input  XLEN  link value from M.
- ValidW  output  1  the W stage holds a real instruction.
- RegWriteW  output  1  register-file write enable.
- RdW  output  5  register-file write address.
- ResultW  output  XLEN  register-file write data; also the forwarding source.
- RetiredCount  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - ValidW=0, RegWriteW=0, RdW=0, ResultW=0, RetiredCount=0.
  - Internal ResultSrcW, ALUResultW, ReadDataW and PCPlus4W all clear to 0.
- Register update priority on each rising edge with rst=0:
  1. FlushW=1: ValidW<=0, RegWriteW<=0, RdW<=0. The data registers may load the M values, but they are don't-care. FlushW wins over StallW.
  2. StallW=1 (no flush): all W registers hold.
  3. Otherwise: load ValidW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdM and PCPlus4W from the M-stage inputs.
- Write-enable qualification on load:
  - RegWriteW <= RegWriteM & ValidM & (RdM != 0).
  - x0 is never written, and a bubble is never written.
- Result mux (combinational from the W registers):
  - 00: ALUResultW.
  - 01: ReadDataW.
  - 10: PCPlus4W.
  - 11: 0.
- ResultW is a pure function of the W registers, with no input-to-output combinational path. Latency from M inputs to W outputs is exactly 1 cycle.
- Retired-instruction counter:
  - Increments by 1 on a rising edge when ValidW=1 and the instruction is leaving W: StallW=0, or FlushW=1.
  - A stalled instruction is counted exactly once, when it finally advances.
  - Wraps modulo 2^CNT_W, from all ones to 0, with no saturation.
- Simultaneous events:
  - Flush and stall together behaves as flush.
  - A stall during a bubble leaves the bubble in place, with no count.
- Reset asserted mid-stall or mid-flush: everything clears immediately; the first edge after deassertion behaves as a normal load.

Test Plan:
- Reset check: with rst=1 and inputs toggling, all outputs read 0. Deassert rst, apply ValidM=1, RegWriteM=1, ResultSrcM=00, ALUResultM=0x0000_1234, RdM=5. One edge later: ResultW=0x1234, RdW=5, RegWriteW=1, ValidW=1. One edge after that: RetiredCount=1.
- Mux coverage: ResultSrcM=01 with ReadDataM=0xDEAD_BEEF gives ResultW=0xDEADBEEF. ResultSrcM=10 with PCPlus4M=0x104 gives 0x104. ResultSrcM=11 gives 0.
- x0 suppression: RegWriteM=1 with RdM=0 gives RegWriteW=0 while ValidW=1, and the counter still increments.
- Stall hold: load instruction A (Rd=7), then hold StallW=1 for 3 cycles while the inputs change to instruction B. Outputs stay on A for those 3 cycles and RetiredCount does not change. After StallW drops, B appears one edge later and the count increases by exactly 1 for A.
- Flush: FlushW=1 and StallW=1 together with a valid M instruction gives ValidW=0, RegWriteW=0 and RdW=0 after the edge. A held valid instruction is counted once on the flush edge.
- Wraparound and async reset: with CNT_W=4, retire 17 instructions and RetiredCount=1. Pulse rst between clock edges and all outputs are 0 before the next edge.
